// File: rtl/genome_pkg.sv
// Shared types and constants for the genome read sequencer.
package genome_pkg;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } seq_state_t;

  // Bytes carried by one stream beat, and the matching byte->beat shift.
  localparam int LP_DW_BYTES   = 64;
  localparam int LP_BEAT_SHIFT = $clog2(LP_DW_BYTES);

endpackage : genome_pkg

// File: rtl/genome_beat_monitor.sv
// Passive per-chunk stream monitor: counts accepted beats, remembers the
// engine's done pulse, and reports chunk completion and beat-count errors.
module genome_beat_monitor #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,            // new chunk issued: reload expectation
  input  logic [CNT_W-1:0] load_beats,     // beats expected for the chunk being issued
  input  logic             active,         // chunk in flight; beats and done counted only now
  input  logic             rd_done,
  input  logic             rd_tvalid,
  input  logic             rd_tready,
  input  logic             rd_tlast,
  output logic             chunk_complete,
  output logic             beat_mismatch
);

  logic [CNT_W-1:0] expected_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             done_seen;
  logic             beat;
  logic             done_any;

  assign beat         = active & rd_tvalid & rd_tready;
  assign beat_cnt_nxt = beat_cnt + {{(CNT_W-1){1'b0}}, beat};
  // The done pulse may precede, coincide with, or follow the final beat.
  assign done_any     = done_seen | (active & rd_done);

  // Beats past the expected count still let the chunk close, so the job
  // cannot stall on an over-long stream; they are only flagged.
  assign chunk_complete = active & done_any & (beat_cnt_nxt >= expected_q);
  assign beat_mismatch  = beat & ((rd_tlast & (beat_cnt_nxt != expected_q)) |
                                  (beat_cnt_nxt > expected_q));

  // Beat counter, done latch and expectation register; cleared on every new chunk.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      expected_q <= '0;
      beat_cnt   <= '0;
      done_seen  <= 1'b0;
    end else if (arm) begin
      expected_q <= load_beats;
      beat_cnt   <= '0;
      done_seen  <= 1'b0;
    end else if (active) begin
      beat_cnt <= beat_cnt_nxt;
      if (rd_done) done_seen <= 1'b1;
    end
  end

endmodule : genome_beat_monitor

// File: rtl/genome_read_sequencer.sv
// Splits one host job (base address + byte count) into fixed-size chunks,
// starts the read engine once per chunk and reports job completion.
module genome_read_sequencer
  import genome_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 4096
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_idle,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  cfg_total_bytes,
  output logic                          rd_start,
  input  logic                          rd_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  rd_xfer_bytes,
  input  logic                          rd_tvalid,
  input  logic                          rd_tready,
  input  logic                          rd_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_idx,
  output logic                          seq_err
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int LP_CHUNK_SHIFT = $clog2(C_CHUNK_BYTES);
  localparam logic [XW-1:0] LP_CHUNK     = XW'(C_CHUNK_BYTES);
  localparam logic [XW-1:0] LP_BEAT_MASK = ~(XW'(C_M_AXI_DATA_WIDTH / 8) - XW'(1));

  seq_state_t    state;
  logic [AW-1:0] base_q;
  logic [XW-1:0] remaining_q;
  logic [XW-1:0] total_masked;
  logic [XW-1:0] chunk_bytes;
  logic [XW-1:0] load_beats;
  logic          chunk_complete;
  logic          beat_mismatch;

  // Partial trailing beats are never requested.
  assign total_masked = cfg_total_bytes & LP_BEAT_MASK;
  assign chunk_bytes  = (remaining_q > LP_CHUNK) ? LP_CHUNK : remaining_q;
  assign load_beats   = chunk_bytes >> LP_BEAT_SHIFT;

  genome_beat_monitor #(
    .CNT_W (XW)
  ) u_beat_monitor (
    .clk            (aclk),
    .rst            (areset),
    .arm            (state == ISSUE),
    .load_beats     (load_beats),
    .active         (state == WAIT),
    .rd_done        (rd_done),
    .rd_tvalid      (rd_tvalid),
    .rd_tready      (rd_tready),
    .rd_tlast       (rd_tlast),
    .chunk_complete (chunk_complete),
    .beat_mismatch  (beat_mismatch)
  );

  // Job FSM with registered handshake, chunk address and status outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      base_q         <= '0;
      remaining_q    <= '0;
      ap_done        <= 1'b0;
      ap_idle        <= 1'b1;
      rd_start       <= 1'b0;
      rd_addr_offset <= '0;
      rd_xfer_bytes  <= '0;
      chunk_idx      <= '0;
      seq_err        <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so each branch only has to
      // raise them; nothing can leave a pulse stuck high.
      rd_start <= 1'b0;
      ap_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            base_q      <= cfg_base_addr;
            remaining_q <= total_masked;
            seq_err     <= 1'b0;
            chunk_idx   <= '0;
            ap_idle     <= 1'b0;
            state       <= (total_masked == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          // Offset wraps modulo the address width by construction.
          rd_addr_offset <= base_q + (AW'(chunk_idx) << LP_CHUNK_SHIFT);
          rd_xfer_bytes  <= chunk_bytes;
          rd_start       <= 1'b1;
          state          <= WAIT;
        end
        WAIT: begin
          if (beat_mismatch) seq_err <= 1'b1;
          if (chunk_complete) begin
            remaining_q <= remaining_q - rd_xfer_bytes;
            if (remaining_q == rd_xfer_bytes) begin
              state <= FIN;
            end else begin
              chunk_idx <= chunk_idx + XW'(1);
              state     <= ISSUE;
            end
          end
        end
        FIN: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : genome_read_sequencer

// File: tb/tb_genome_read_sequencer.sv
// Self-checking bench for genome_read_sequencer: a job-level chunk model
// plus a per-cycle compare process and directed timing/status checks.
module tb_genome_read_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic [63:0] cfg_base_addr;
  logic [31:0] cfg_total_bytes;
  logic        rd_start;
  logic        rd_done;
  logic [63:0] rd_addr_offset;
  logic [31:0] rd_xfer_bytes;
  logic        rd_tvalid;
  logic        rd_tready;
  logic        rd_tlast;
  logic [31:0] chunk_idx;
  logic        seq_err;

  always #5 aclk = ~aclk;

  genome_read_sequencer #(
    .C_M_AXI_ADDR_WIDTH (64),
    .C_M_AXI_DATA_WIDTH (512),
    .C_XFER_SIZE_WIDTH  (32),
    .C_CHUNK_BYTES      (4096)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_total_bytes (cfg_total_bytes),
    .rd_start        (rd_start),
    .rd_done         (rd_done),
    .rd_addr_offset  (rd_addr_offset),
    .rd_xfer_bytes   (rd_xfer_bytes),
    .rd_tvalid       (rd_tvalid),
    .rd_tready       (rd_tready),
    .rd_tlast        (rd_tlast),
    .chunk_idx       (chunk_idx),
    .seq_err         (seq_err)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] bytes;
    logic [31:0] idx;
    int          cyc;
  } chunk_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  chunk_t      exp_q[$];
  chunk_t      obs_q[$];
  chunk_t      cmp_e;
  chunk_t      obs_e;
  bit          done_pending = 1'b0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic        last_done_seq_err = 1'b0;
  logic [63:0] exp_addr = '0;
  logic [31:0] exp_bytes = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model: the chunk list a job must produce, from plain arithmetic.
  function automatic void model_job(input logic [63:0] base, input logic [31:0] total);
    longint unsigned rem = longint'(total) - longint'(total % 64);
    int unsigned     idx = 0;
    chunk_t          c;
    while (rem > 0) begin
      c.addr  = base + 64'(idx) * 64'd4096;
      c.bytes = (rem > 4096) ? 32'd4096 : 32'(rem);
      c.idx   = idx;
      c.cyc   = 0;
      exp_q.push_back(c);
      rem -= c.bytes;
      idx++;
    end
    done_pending = 1'b1;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge aclk) begin
    if (!areset) begin
      if (rd_start) begin
        check("rd_start_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cmp_e = exp_q.pop_front();
          check("chunk_addr", rd_addr_offset, cmp_e.addr);
          check("chunk_bytes", 64'(rd_xfer_bytes), 64'(cmp_e.bytes));
          check("chunk_idx", 64'(chunk_idx), 64'(cmp_e.idx));
          exp_addr  = cmp_e.addr;
          exp_bytes = cmp_e.bytes;
        end
        obs_e.addr  = rd_addr_offset;
        obs_e.bytes = rd_xfer_bytes;
        obs_e.idx   = chunk_idx;
        obs_e.cyc   = cyc;
        obs_q.push_back(obs_e);
      end
      check("addr_stable", rd_addr_offset, exp_addr);
      check("bytes_stable", 64'(rd_xfer_bytes), 64'(exp_bytes));
      if (ap_done) begin
        check("ap_done_expected", 64'(done_pending && exp_q.size() == 0), 64'd1);
        done_pending      = 1'b0;
        done_cnt++;
        last_done_cyc     = cyc;
        last_done_seq_err = seq_err;
      end
    end
  end

  task automatic launch(input logic [63:0] base, input logic [31:0] total, output int s);
    model_job(base, total);
    @(posedge aclk); #1;
    s               = cyc;
    cfg_base_addr   = base;
    cfg_total_bytes = total;
    ap_start        = 1'b1;
    @(posedge aclk); #1;
    ap_start        = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 500; i++) begin
      @(posedge aclk); #2;
      if (obs_q.size() >= n) break;
    end
    check("wait_rd_start", 64'(obs_q.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 500; i++) begin
      @(posedge aclk); #2;
      if (done_cnt >= n) break;
    end
    check("wait_ap_done", 64'(done_cnt >= n), 64'd1);
  endtask

  // Emulated engine: back-to-back beats from cycle 0; done and tlast at given
  // cycle indices. Returns the cycle of the later of last beat and done.
  task automatic serve(input int beats, input int done_at, input int tlast_at, output int ev);
    int span = (beats > done_at + 1) ? beats : done_at + 1;
    ev = cyc;
    for (int c = 0; c < span; c++) begin
      if (c > 0) begin
        @(posedge aclk); #1;
      end
      rd_tvalid = (c < beats);
      rd_tready = (c < beats);
      rd_tlast  = (c == tlast_at);
      rd_done   = (c == done_at);
      if (c == beats - 1 || c == done_at) ev = cyc;
    end
    @(posedge aclk); #1;
    rd_tvalid = 1'b0;
    rd_tready = 1'b0;
    rd_tlast  = 1'b0;
    rd_done   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int ev;
    areset = 1'b1;
    ap_start = 1'b0;
    cfg_base_addr = '0;
    cfg_total_bytes = '0;
    rd_done = 1'b0;
    rd_tvalid = 1'b0;
    rd_tready = 1'b0;
    rd_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ap_idle", 64'(ap_idle), 64'd1);
    check("rst_ap_done", 64'(ap_done), 64'd0);
    check("rst_rd_start", 64'(rd_start), 64'd0);
    check("rst_addr", rd_addr_offset, 64'd0);
    check("rst_bytes", 64'(rd_xfer_bytes), 64'd0);
    check("rst_chunk_idx", 64'(chunk_idx), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    areset = 1'b0;

    // Two full chunks; done early on chunk 0, same cycle as last beat on chunk 1.
    launch(64'h1000, 32'd8192, s);
    wait_starts(1);
    check("A0_latency", 64'(obs_q[0].cyc), 64'(s + 2));
    check("A0_addr_lit", obs_q[0].addr, 64'h1000);
    check("A0_bytes_lit", 64'(obs_q[0].bytes), 64'd4096);
    check("A_busy_idle", 64'(ap_idle), 64'd0);
    serve(64, 58, 63, ev);
    wait_starts(2);
    check("A1_latency_early_done", 64'(obs_q[1].cyc), 64'(ev + 2));
    check("A1_addr_lit", obs_q[1].addr, 64'h2000);
    check("A1_idx_lit", 64'(obs_q[1].idx), 64'd1);
    serve(64, 63, 63, ev);
    wait_done(1);
    check("A_done_latency_same_cycle", 64'(last_done_cyc), 64'(ev + 2));
    check("A_idle_after", 64'(ap_idle), 64'd1);
    check("A_seq_err", 64'(seq_err), 64'd0);

    // 4160 bytes (low bits of 4177 ignored): 4096 + 64; done after last beat.
    launch(64'h0000_00AB_CDE0_0000, 32'd4177, s);
    wait_starts(3);
    serve(64, 66, 63, ev);
    wait_starts(4);
    check("B1_latency_late_done", 64'(obs_q[3].cyc), 64'(ev + 2));
    check("B1_addr_lit", obs_q[3].addr, 64'h0000_00AB_CDE0_1000);
    check("B1_bytes_lit", 64'(obs_q[3].bytes), 64'd64);
    check("B1_idx_lit", 64'(obs_q[3].idx), 64'd1);
    serve(1, 0, 0, ev);
    wait_done(2);
    check("B_done_latency", 64'(last_done_cyc), 64'(ev + 2));
    check("B_done_count", 64'(done_cnt), 64'd2);

    // Zero-length jobs: done two cycles after start, no engine starts.
    launch(64'h5000, 32'd0, s);
    wait_done(3);
    check("C0_done_latency", 64'(last_done_cyc), 64'(s + 2));
    launch(64'h5000, 32'd63, s);
    wait_done(4);
    check("C63_done_latency", 64'(last_done_cyc), 64'(s + 2));
    check("C_no_starts", 64'(obs_q.size()), 64'd4);
    check("C_idle_after", 64'(ap_idle), 64'd1);

    // Early tlast on beat 63 of 64; address wraps into chunk 1; ap_start while busy ignored.
    launch(64'hFFFF_FFFF_FFFF_F000, 32'd8192, s);
    wait_starts(5);
    serve(64, 63, 62, ev);
    check("D_seq_err_set", 64'(seq_err), 64'd1);
    wait_starts(6);
    check("D1_wrap_addr_lit", obs_q[5].addr, 64'h0);
    cfg_total_bytes = 32'd4096;
    ap_start = 1'b1;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    serve(64, 63, 63, ev);
    wait_done(5);
    check("D_seq_err_at_done", 64'(last_done_seq_err), 64'd1);
    check("D_busy_start_ignored", 64'(obs_q.size()), 64'd6);

    // Next accepted start clears seq_err; a beat beyond expected sets it again.
    launch(64'h40, 32'd64, s);
    check("E_seq_err_cleared", 64'(seq_err), 64'd0);
    wait_starts(7);
    serve(2, 1, 1, ev);
    check("E_extra_beat_err", 64'(seq_err), 64'd1);
    wait_done(6);
    check("E_done_latency", 64'(last_done_cyc), 64'(ev + 2));

    // Reset mid-WAIT with ap_start high aborts immediately.
    launch(64'h0, 32'd8192, s);
    wait_starts(8);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge aclk); #1;
      end
      rd_tvalid = 1'b1;
      rd_tready = 1'b1;
    end
    @(posedge aclk); #1;
    rd_tvalid = 1'b0;
    rd_tready = 1'b0;
    ap_start  = 1'b1;
    areset    = 1'b1;
    #1;
    check("R_rd_start", 64'(rd_start), 64'd0);
    check("R_ap_done", 64'(ap_done), 64'd0);
    check("R_ap_idle", 64'(ap_idle), 64'd1);
    check("R_addr", rd_addr_offset, 64'd0);
    check("R_bytes", 64'(rd_xfer_bytes), 64'd0);
    check("R_chunk_idx", 64'(chunk_idx), 64'd0);
    exp_q.delete();
    done_pending = 1'b0;
    exp_addr = '0;
    exp_bytes = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset   = 1'b0;
    ap_start = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    check("R_no_start_after", 64'(obs_q.size()), 64'd8);
    check("R_idle_after", 64'(ap_idle), 64'd1);

    launch(64'h80, 32'd128, s);
    wait_starts(9);
    check("G_latency", 64'(obs_q[8].cyc), 64'(s + 2));
    check("G_addr_lit", obs_q[8].addr, 64'h80);
    check("G_bytes_lit", 64'(obs_q[8].bytes), 64'd128);
    serve(2, 1, 1, ev);
    wait_done(7);
    check("G_seq_err", 64'(seq_err), 64'd0);
    check("G_done_latency", 64'(last_done_cyc), 64'(ev + 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_genome_read_sequencer
